// File: rtl/mcoi_reset_sequencer.sv
// Ordered power-on reset sequencer: releases NSTAGES active-high resets one at a time,
// each gated by its own lock condition, with request filtering and lock-loss recovery.
module mcoi_reset_sequencer #(
    parameter int NSTAGES     = 4,
    parameter int POR_CYCLES  = 2097151,
    parameter int STAGE_DELAY = 1024,
    parameter int FILTER_LEN  = 8
) (
    input  logic                               clk_ik,
    input  logic                               rst_irn,
    input  logic                               req_reset_i,
    input  logic [NSTAGES-1:0]                 lock_i,
    output logic [NSTAGES-1:0]                 reset_o,
    output logic                               all_released_o,
    output logic [$clog2(NSTAGES+1)-1:0]       stage_o,
    output logic                               lock_lost_o
);

    localparam int CNT_MAX = (POR_CYCLES > STAGE_DELAY) ? POR_CYCLES : STAGE_DELAY;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int SW      = $clog2(NSTAGES + 1);
    localparam int FW      = $clog2(FILTER_LEN + 1);

    localparam logic [CW-1:0] POR_LAST  = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST  = CW'(STAGE_DELAY - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] FILT_FULL = FW'(FILTER_LEN);
    localparam logic [SW-1:0] LAST_STG  = SW'(NSTAGES - 1);
    localparam logic [SW-1:0] RUN_STG   = SW'(NSTAGES);

    typedef enum logic [2:0] {
        S_POR,
        S_HOLD,
        S_WAIT,
        S_DELAY,
        S_RUN
    } state_t;

    logic               req_meta, req_sync;
    logic [NSTAGES-1:0] lock_meta, lock_sync;
    logic [FW-1:0]      filt_cnt;
    logic               fire;

    state_t             state_q, state_d;
    logic [SW-1:0]      stage_q, stage_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NSTAGES-1:0] reset_q, reset_d;
    logic               all_rel_q;
    logic               lost_q, lost_d;

    logic               lock_cur;
    logic               loss;
    logic [SW-1:0]      loss_idx;

    always_ff @(posedge clk_ik or negedge rst_irn) begin
        if (!rst_irn) begin
            req_meta  <= 1'b0;
            req_sync  <= 1'b0;
            lock_meta <= '0;
            lock_sync <= '0;
        end else begin
            req_meta  <= req_reset_i;
            req_sync  <= req_meta;
            lock_meta <= lock_i;
            lock_sync <= lock_meta;
        end
    end

    // Saturating filter: fire is a registered pulse on reaching FILTER_LEN, so a held
    // request fires once and re-arms only after the synced request drops.
    always_ff @(posedge clk_ik or negedge rst_irn) begin
        if (!rst_irn) begin
            filt_cnt <= '0;
            fire     <= 1'b0;
        end else if (req_sync) begin
            if (filt_cnt != FILT_FULL) begin
                filt_cnt <= filt_cnt + 1'b1;
            end
            fire <= (filt_cnt == FILT_LAST);
        end else begin
            filt_cnt <= '0;
            fire     <= 1'b0;
        end
    end

    always_ff @(posedge clk_ik or negedge rst_irn) begin
        if (!rst_irn) begin
            state_q   <= S_POR;
            stage_q   <= '0;
            cnt_q     <= '0;
            reset_q   <= '1;
            all_rel_q <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            cnt_q     <= cnt_d;
            reset_q   <= reset_d;
            all_rel_q <= (state_d == S_RUN);
            lost_q    <= lost_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        cnt_d    = cnt_q;
        reset_d  = reset_q;
        lost_d   = 1'b0;
        lock_cur = 1'b0;
        loss     = 1'b0;
        loss_idx = '0;

        for (int k = 0; k < NSTAGES; k++) begin
            if (SW'(k) == stage_q) lock_cur = lock_sync[k];
        end
        // Descending scan so the lowest lost stage is the one that sticks.
        for (int j = NSTAGES - 1; j >= 0; j--) begin
            if ((SW'(j) < stage_q) && !lock_sync[j]) begin
                loss     = 1'b1;
                loss_idx = SW'(j);
            end
        end

        if (fire && (state_q != S_POR)) begin
            state_d = S_HOLD;
            stage_d = '0;
            cnt_d   = '0;
            reset_d = '1;
        end else if (loss) begin
            state_d = S_WAIT;
            stage_d = loss_idx;
            cnt_d   = '0;
            lost_d  = 1'b1;
            for (int k = 0; k < NSTAGES; k++) begin
                if (SW'(k) >= loss_idx) reset_d[k] = 1'b1;
            end
        end else begin
            case (state_q)
                S_POR: begin
                    if (cnt_q == POR_LAST) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (req_sync) begin
                        cnt_d = '0;
                    end else if (cnt_q == DLY_LAST) begin
                        state_d = S_WAIT;
                        stage_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (lock_cur) begin
                        state_d = S_DELAY;
                        cnt_d   = '0;
                    end
                end
                S_DELAY: begin
                    if (!lock_cur) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == DLY_LAST) begin
                        cnt_d = '0;
                        for (int k = 0; k < NSTAGES; k++) begin
                            if (SW'(k) == stage_q) reset_d[k] = 1'b0;
                        end
                        if (stage_q == LAST_STG) begin
                            state_d = S_RUN;
                            stage_d = RUN_STG;
                        end else begin
                            state_d = S_WAIT;
                            stage_d = stage_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    state_d = S_RUN;
                end
                default: begin
                    state_d = S_POR;
                    stage_d = '0;
                    cnt_d   = '0;
                    reset_d = '1;
                end
            endcase
        end
    end

    assign reset_o        = reset_q;
    assign all_released_o = all_rel_q;
    assign stage_o        = stage_q;
    assign lock_lost_o    = lost_q;

endmodule
